// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and Q-format helpers for the sequential FIR
// Contents: controller state encoding, clog2, Q1.(dw-1) range limits and a
//           saturating clamp, all evaluated on a wide signed carrier type.
package fir_pkg;

  // Carrier for saturation arithmetic; wide enough for any DATA_WIDTH <= 32.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Largest representable Q1.(dw-1) value as a raw integer.
  function automatic wide_t q_max(input int dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction

  // Most negative representable Q1.(dw-1) value as a raw integer.
  function automatic wide_t q_min(input int dw);
    return -(wide_t'(1) <<< (dw - 1));
  endfunction

  function automatic wide_t saturate(input wide_t v, input int dw);
    if (v > q_max(dw)) return q_max(dw);
    else if (v < q_min(dw)) return q_min(dw);
    else return v;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - combinational multiply, rescale, accumulate and saturate
// Ports:
//   coef, sample  in   signed Q1.(DATA_WIDTH-1) operands
//   acc_in        in   running accumulator (ACC_W bits)
//   acc_out       out  acc_in + rescaled product
//   sat_out       out  acc_out clamped to the DATA_WIDTH range
//   ovf           out  high when the clamp changed the value
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ACC_W      = 29
) (
  input  logic signed [DATA_WIDTH-1:0] coef,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [ACC_W-1:0]      acc_in,
  output logic signed [ACC_W-1:0]      acc_out,
  output logic signed [DATA_WIDTH-1:0] sat_out,
  output logic                         ovf
);

  localparam int PW = 2 * DATA_WIDTH;
  // One bit of headroom over the wider operand so the sum itself never wraps.
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_shr;
  logic signed [SW-1:0] sum_full;
  wide_t                sat_wide;

  assign prod     = PW'(coef) * PW'(sample);
  // Arithmetic shift back to Q1.(DATA_WIDTH-1): truncates toward -inf.
  assign prod_shr = prod >>> (DATA_WIDTH - 1);
  assign sum_full = SW'(prod_shr) + SW'(acc_in);
  assign acc_out  = sum_full[ACC_W-1:0];

  assign sat_wide = saturate(wide_t'(sum_full), DATA_WIDTH);
  assign sat_out  = DATA_WIDTH'(sat_wide);
  assign ovf      = (sat_wide != wide_t'(sum_full));

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - time-multiplexed FIR controller around one shared MAC
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_coef_we/iv_coef_addr/iv_coef_data coefficient write port (IDLE only)
//   o_coef_err                          one-cycle pulse on a dropped write
//   i_clear                             zero the sample history
//   i_in_valid/o_in_ready/iv_din        input sample handshake
//   o_out_valid/i_out_ready/ov_dout     result handshake, saturated output
//   o_sum_overflow                      result was clamped
//   o_busy                              controller not in IDLE
// NUM_TAPS must be at least 2.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_coef_we,
  input  logic [clog2(NUM_TAPS)-1:0]    iv_coef_addr,
  input  logic signed [DATA_WIDTH-1:0]  iv_coef_data,
  output logic                          o_coef_err,
  input  logic                          i_clear,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic signed [DATA_WIDTH-1:0]  iv_din,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic signed [DATA_WIDTH-1:0]  ov_dout,
  output logic                          o_sum_overflow,
  output logic                          o_busy
);

  localparam int AW    = clog2(NUM_TAPS);
  localparam int ACC_W = DATA_WIDTH + AW + 1;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] smp_buf  [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] coef_mem [NUM_TAPS];

  logic signed [ACC_W-1:0]      acc, acc_nxt;
  logic [AW-1:0]                wr_ptr, base, k, tap_idx;
  logic                         k_last, accept, addr_ok, coef_ok;
  logic signed [DATA_WIDTH-1:0] sat_res;
  logic                         ovf_res;

  assign k_last  = (k == AW'(NUM_TAPS - 1));
  assign accept  = (state == S_IDLE) && !i_clear && i_in_valid;
  // Only reachable when NUM_TAPS is not a power of two.
  assign addr_ok = ({1'b0, iv_coef_addr} < (AW + 1)'(NUM_TAPS));
  assign coef_ok = (state == S_IDLE) && addr_ok;

  // Newest sample sits at base; tap k reads k samples back, modulo NUM_TAPS.
  always_comb begin
    if (base >= k) tap_idx = base - k;
    else           tap_idx = AW'({1'b0, base} + (AW + 1)'(NUM_TAPS) - {1'b0, k});
  end

  fir_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_mac (
    .coef    (coef_mem[k]),
    .sample  (smp_buf[tap_idx]),
    .acc_in  (acc),
    .acc_out (acc_nxt),
    .sat_out (sat_res),
    .ovf     (ovf_res)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_clear)         state_nxt = S_CLEAR;
        else if (i_in_valid) state_nxt = S_MAC;
      end
      S_CLEAR: if (k_last) state_nxt = S_IDLE;
      S_MAC:   if (k_last) state_nxt = S_OUT;
      S_OUT:   if (i_out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake / status outputs; ready is also forced low while reset is held.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (state)
      S_IDLE: begin
        o_in_ready = i_rst_n;
        o_busy     = 1'b0;
      end
      S_OUT:   o_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: history buffer, coefficient file, counters and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        smp_buf[i]  <= '0;
        coef_mem[i] <= '0;
      end
      acc            <= '0;
      wr_ptr         <= '0;
      base           <= '0;
      k              <= '0;
      ov_dout        <= '0;
      o_sum_overflow <= 1'b0;
      o_coef_err     <= 1'b0;
    end else begin
      o_coef_err <= i_coef_we && !coef_ok;
      if (i_coef_we && coef_ok) coef_mem[iv_coef_addr] <= iv_coef_data;

      case (state)
        S_IDLE: begin
          if (i_clear) begin
            k <= '0;
          end else if (accept) begin
            smp_buf[wr_ptr] <= iv_din;
            base            <= wr_ptr;
            wr_ptr          <= (wr_ptr == AW'(NUM_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
            acc             <= '0;
            k               <= '0;
          end
        end
        S_CLEAR: begin
          smp_buf[k] <= '0;
          wr_ptr     <= '0;
          k          <= k_last ? '0 : k + 1'b1;
        end
        S_MAC: begin
          if (k_last) begin
            // Final tap: the clamp sees acc plus this last product directly.
            ov_dout        <= sat_res;
            o_sum_overflow <= ovf_res;
            k              <= '0;
          end else begin
            acc <= acc_nxt;
            k   <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

  localparam int DW = 8;
  localparam int NT = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b1;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [DW-1:0] coef_data = '0;
  logic                 coef_err;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] din = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] dout;
  logic                 sum_ovf;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  fir_seq_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_coef_we      (coef_we),
    .iv_coef_addr   (coef_addr),
    .iv_coef_data   (coef_data),
    .o_coef_err     (coef_err),
    .i_clear        (clear),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .iv_din         (din),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .ov_dout        (dout),
    .o_sum_overflow (sum_ovf),
    .o_busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic signed [DW-1:0] d);
    coef_addr = a;
    coef_data = d;
    coef_we   = 1'b1;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic send(input logic signed [DW-1:0] d, output int waited);
    waited = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    in_valid = 1'b1;
    din      = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic signed [DW-1:0] d, output logic o, output int lat);
    lat       = 0;
    out_ready = 1'b1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    d = dout;
    o = sum_ovf;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic signed [DW-1:0] d;
    logic o;
    int w, lat;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, coef_err, sum_ovf, dout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b err=%b ovf=%b dout=%0d required all 0",
               in_ready, out_valid, busy, coef_err, sum_ovf, dout);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
    // Coefficients reset to zero, so any sample must produce 0.
    send(8'sd100, w);
    recv(d, o, lat);
    checks++;
    if (d !== 8'sd0 || o !== 1'b0) begin
      errors++;
      $display("FAIL reset_coefs_zero: got dout=%0d ovf=%b required 0/0", d, o);
    end
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] d;
    logic o;
    int w, lat;
    apply_reset();
    write_coef(0, 8'sd64);
    send(8'sd100, w);
    recv(d, o, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges required 4", lat);
    end
    checks++;
    if (d !== 8'sd50 || o !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got dout=%0d ovf=%b required 50/0", d, o);
    end
  endtask

  task automatic test_impulse();
    logic signed [DW-1:0] smp [4] = '{8'sd127, 8'sd0, 8'sd0, 8'sd0};
    logic signed [DW-1:0] exp_d [4] = '{8'sd9, 8'sd19, 8'sd29, 8'sd39};
    logic signed [DW-1:0] d;
    logic o;
    int w, lat;
    apply_reset();
    write_coef(0, 8'sd10);
    write_coef(1, 8'sd20);
    write_coef(2, 8'sd30);
    write_coef(3, 8'sd40);
    for (int i = 0; i < 4; i++) begin
      send(smp[i], w);
      recv(d, o, lat);
      checks++;
      if (d !== exp_d[i] || o !== 1'b0) begin
        errors++;
        $display("FAIL impulse_%0d: got dout=%0d ovf=%b required %0d/0", i, d, o, exp_d[i]);
      end
    end
  endtask

  task automatic test_pos_sat();
    logic signed [DW-1:0] exp_d [4] = '{8'sd126, 8'sd127, 8'sd127, 8'sd127};
    logic exp_o [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic signed [DW-1:0] d;
    logic o;
    int w, lat;
    apply_reset();
    for (int i = 0; i < 4; i++) write_coef(AW'(i), 8'sd127);
    for (int i = 0; i < 4; i++) begin
      send(8'sd127, w);
      recv(d, o, lat);
      checks++;
      if (d !== exp_d[i] || o !== exp_o[i]) begin
        errors++;
        $display("FAIL pos_sat_%0d: got dout=%0d ovf=%b required %0d/%b", i, d, o, exp_d[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_neg_sat();
    logic signed [DW-1:0] exp_d [2] = '{-8'sd127, 8'sh80};
    logic exp_o [2] = '{1'b0, 1'b1};
    logic signed [DW-1:0] d;
    logic o;
    int w, lat, cnt;
    // History still holds the +127 samples; clear it and keep the coefficients.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 50) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      send(8'sh80, w);
      recv(d, o, lat);
      checks++;
      if (d !== exp_d[i] || o !== exp_o[i]) begin
        errors++;
        $display("FAIL neg_sat_%0d: got dout=%0d ovf=%b required %0d/%b", i, d, o, exp_d[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] d;
    logic o;
    int w, lat, cnt;
    apply_reset();
    write_coef(0, 8'sd64);
    send(8'sd100, w);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    in_valid = 1'b1;
    din      = 8'sd20;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== 8'sd50) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b dout=%0d required 1/0/50", i, out_valid, in_ready, dout);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 8'sd50) begin
      errors++;
      $display("FAIL bp_after_handshake: got vld=%b rdy=%b dout=%0d required 0/1/50", out_valid, in_ready, dout);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept: got busy=%b required 1", busy);
    end
    recv(d, o, lat);
    checks++;
    if (lat !== 4 || d !== 8'sd10) begin
      errors++;
      $display("FAIL bp_second_result: got lat=%0d dout=%0d required 4/10", lat, d);
    end
  endtask

  task automatic test_dropped_write();
    logic signed [DW-1:0] d;
    logic o;
    int w, lat;
    apply_reset();
    write_coef(0, 8'sd64);
    send(8'sd100, w);
    tick();
    coef_addr = 0;
    coef_data = 8'sd0;
    coef_we   = 1'b1;
    tick();
    coef_we   = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_err_pulse: got %b required 1", coef_err);
    end
    tick();
    checks++;
    if (coef_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_err_width: got %b required 0", coef_err);
    end
    recv(d, o, lat);
    checks++;
    if (d !== 8'sd50) begin
      errors++;
      $display("FAIL drop_result: got %0d required 50", d);
    end
    send(8'sd100, w);
    recv(d, o, lat);
    checks++;
    if (d !== 8'sd50) begin
      errors++;
      $display("FAIL drop_coef_kept: got %0d required 50", d);
    end
  endtask

  task automatic test_clear_reset();
    logic signed [DW-1:0] d;
    logic o;
    int w, lat, cnt;
    logic seen;
    apply_reset();
    for (int i = 0; i < 4; i++) write_coef(AW'(i), 8'sd64);
    send(8'sd100, w);
    recv(d, o, lat);
    send(8'sd100, w);
    recv(d, o, lat);
    checks++;
    if (d !== 8'sd100) begin
      errors++;
      $display("FAIL clr_prefill: got %0d required 100", d);
    end
    // Clear wins over a simultaneous sample.
    clear    = 1'b1;
    in_valid = 1'b1;
    din      = 8'sd77;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_enter: got busy=%b rdy=%b vld=%b required 1/0/0", busy, in_ready, out_valid);
    end
    cnt = 0;
    while (busy && cnt < 50) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== NT) begin
      errors++;
      $display("FAIL clr_duration: got %0d cycles required %0d", cnt, NT);
    end
    send(8'sd50, w);
    recv(d, o, lat);
    checks++;
    if (d !== 8'sd25 || o !== 1'b0) begin
      errors++;
      $display("FAIL clr_result: got dout=%0d ovf=%b required 25/0", d, o);
    end
    send(8'sd100, w);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, sum_ovf, coef_err, dout} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid_mac: got vld=%b busy=%b rdy=%b ovf=%b err=%b dout=%0d required all 0",
               out_valid, busy, in_ready, sum_ovf, coef_err, dout);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: got rdy=%b busy=%b required 1/0", in_ready, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_result: got out_valid seen=%b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_impulse();
    test_pos_sat();
    test_neg_sat();
    test_backpressure();
    test_dropped_write();
    test_clear_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Time-multiplexed FIR controller: one shared multiply-accumulate datapath computes every tap of an NUM_TAPS-tap filter in sequence, in place of a chain of parallel tap stages.
- Owns the sample history ring buffer, the coefficient register file, the tap-index counter and the input/output valid/ready handshakes.
- Sits between the sample source and the downstream consumer of the filter output.

Parameters:
- DATA_WIDTH, 24, width of samples, coefficients and output; signed Q1.(DATA_WIDTH-1).
- NUM_TAPS, 16, number of taps; must be at least 2.
- Derived localparams, not overridable:
  - AW = clog2(NUM_TAPS).
  - ACC_W = DATA_WIDTH + AW + 1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_coef_we  in  1  coefficient write strobe.
- iv_coef_addr  in  AW  coefficient index, 0..NUM_TAPS-1.
- iv_coef_data  in  DATA_WIDTH  signed coefficient.
- o_coef_err  out  1  one-cycle pulse: coefficient write was dropped.
- i_clear  in  1  request to zero the sample history.
- i_in_valid  in  1  input sample valid.
- o_in_ready  out  1  controller can accept a sample.
- iv_din  in  DATA_WIDTH  signed input sample.
- o_out_valid  out  1  filter result valid.
- i_out_ready  in  1  consumer accepts the result.
- ov_dout  out  DATA_WIDTH  saturated filter result.
- o_sum_overflow  out  1  saturation occurred for the current result.
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - Sample buffer, coefficients, accumulator, write pointer and tap counter are all 0.
  - Outputs: ov_dout=0, o_out_valid=0, o_sum_overflow=0, o_coef_err=0, o_busy=0, o_in_ready=0 while reset is asserted.
  - Reset mid-operation aborts the computation; no result is emitted.
- States: IDLE, CLEAR, MAC, OUT.
- IDLE:
  - o_in_ready=1.
  - If i_clear=1: go to CLEAR. Clear has priority over i_in_valid, and no sample is accepted that cycle.
  - Else, on i_in_valid & o_in_ready:
    - write iv_din to buf[wr_ptr];
    - latch base=wr_ptr;
    - advance wr_ptr with wrap NUM_TAPS-1 -> 0;
    - acc=0, k=0;
    - go to MAC.
- CLEAR:
  - Zeroes one buffer entry per cycle, k = 0..NUM_TAPS-1.
  - wr_ptr is reset to 0.
  - Returns to IDLE after NUM_TAPS cycles.
  - o_in_ready=0 throughout.
- MAC, one tap per cycle:
  - p_k = (coef[k] * buf[(base-k) mod NUM_TAPS]), full 2*DATA_WIDTH product, arithmetic-shifted right by DATA_WIDTH-1 (truncation toward -inf).
  - acc += p_k, with sign extension to ACC_W.
  - On the edge where k=NUM_TAPS-1:
    - ov_dout = acc+p_k saturated to [-2^(DW-1), 2^(DW-1)-1];
    - o_sum_overflow = 1 if saturation occurred;
    - go to OUT.
- OUT:
  - o_out_valid=1; ov_dout and o_sum_overflow are held stable.
  - On i_out_ready, go to IDLE; o_out_valid drops on the following edge.
  - ov_dout and o_sum_overflow retain their values after the handshake.
- Latency: the result is registered NUM_TAPS edges after the accepting edge.
- Throughput: one sample per NUM_TAPS+2 cycles when i_out_ready=1.
- Coefficient writes:
  - Take effect on the edge of a strobe when state=IDLE.
  - In any other state the write is dropped and o_coef_err pulses high for exactly one cycle.
  - A write in the same IDLE cycle as a sample accept is applied and is used by that computation.
  - An out-of-range address (only possible when NUM_TAPS is not a power of two) is dropped and flagged the same way.

Decomposition:
- Shared package fir_pkg: Q-format helpers, the saturate function, the clog2 function, and the state encoding.
- One natural sub-module: fir_mac_unit.
  - Combinational product, shift and accumulate-add, plus saturation/overflow detection.
  - Parameterised on DATA_WIDTH and ACC_W.
- Controller, buffer and coefficient file stay in fir_seq_ctrl.

Test Plan (DATA_WIDTH=8, NUM_TAPS=4):
- Basic result and latency: coefs {64,0,0,0}, send 100 -> ov_dout=50, o_sum_overflow=0, o_out_valid 4 edges after accept.
- Impulse response: coefs {10,20,30,40}, samples 127,0,0,0 -> outputs 9,19,29,39 in order.
- Positive saturation: all coefs 127, samples 127 x4 -> outputs 126 (ovf 0), 127 (ovf 1), 127 (ovf 1), 127 (ovf 1).
- Negative saturation: all coefs 127, samples -128 x2 -> outputs -127 (ovf 0), -128 (ovf 1).
- Backpressure: hold i_out_ready=0 for 5 cycles with i_in_valid=1 -> ov_dout stable, o_in_ready=0, second sample accepted only after the output handshake.
- Dropped write: write coef[0]=0 during MAC -> o_coef_err one-cycle pulse, result uses the old coefficient.
- Clear, then reset mid-MAC:
  - i_clear followed by sample 50 -> only tap 0 contributes.
  - Deasserting i_rst_n during MAC -> all outputs 0 immediately; o_in_ready=1 in IDLE after release.
